// File: rtl/trace_pkg.sv
// Shared types and field positions for the retire-trace capture path.
// Defining TRACE_CAPTURE_STAMP_EN appends a 32-bit cycle stamp to every record.
package trace_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      PUSH = 2'd2
   } state_e;

   localparam int RS_MSB = 25;
   localparam int RS_LSB = 21;
   localparam int RT_MSB = 20;
   localparam int RT_LSB = 16;

   typedef struct packed {
      logic [31:0] retire_pc;
      logic [31:0] pc;
      logic [31:0] rs_value;
      logic [31:0] rt_value;
      logic [31:0] rd_value;
`ifdef TRACE_CAPTURE_STAMP_EN
      logic [31:0] stamp;
`endif
   } trace_rec_t;

   localparam int REC_W = $bits(trace_rec_t);

endpackage

// File: rtl/trace_fifo.sv
// Record FIFO; a push while full is accepted only when a pop lands on the same edge.
module trace_fifo
   import trace_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int WIDTH = REC_W
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic [WIDTH-1:0]       data_i,
   output logic [WIDTH-1:0]       data_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q;
   logic [AW-1:0]    rptr_q;
   logic [AW:0]      count_q;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   // Head is read combinationally, so a full push+pop overwrites the slot after it is consumed.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= data_i;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + 1'b1;
         if (do_pop)  rptr_q <= rptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign data_o  = empty_o ? '0 : mem_q[rptr_q];

endmodule

// File: rtl/trace_capture.sv
// Retire-trace capture: selects rs/rt, samples register data and PC, queues records for the host.
// TRACE_CAPTURE_STAMP_EN adds a free-running cycle stamp as the record LSBs.
//
//   state | meaning
//   IDLE  | ready for a retire; latch PC and register selects on retire_valid
//   READ  | selects held, counting down READ_LAT; sample record when count hits 1
//   PUSH  | write record to FIFO, or drop it and bump drop_cnt when full
module trace_capture
   import trace_pkg::*;
#(
   parameter int DEPTH    = 16,
   parameter int READ_LAT = 1
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   retire_valid,
   output logic                   retire_ready,
   input  logic [31:0]            retire_instr,
   input  logic [31:0]            retire_pc,
   output logic [4:0]             rs,
   output logic [4:0]             rt,
   input  logic [31:0]            rs_value,
   input  logic [31:0]            rt_value,
   input  logic [31:0]            rd_value,
   input  logic [31:0]            pc,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [REC_W-1:0]       out_data,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic [15:0]            drop_cnt
);

   localparam logic [1:0] ST_IDLE = IDLE;
   localparam logic [1:0] ST_READ = READ;
   localparam logic [1:0] ST_PUSH = PUSH;
   localparam int         CW      = $clog2(READ_LAT + 1);

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [4:0]    rs_q, rs_d;
   logic [4:0]    rt_q, rt_d;
   logic [31:0]   rpc_q, rpc_d;
   trace_rec_t    rec_q, rec_d;
   logic [15:0]   drop_q, drop_d;
   logic          fifo_push;
   logic          fifo_pop;
   logic          fifo_full;
   logic          fifo_empty;
   logic          unused_instr;

   assign unused_instr = ^{retire_instr[31:RS_MSB+1], retire_instr[RT_LSB-1:0]};

`ifdef TRACE_CAPTURE_STAMP_EN
   logic [31:0] stamp_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) stamp_q <= '0;
      else          stamp_q <= stamp_q + 32'd1;
   end
`endif

   assign fifo_pop = out_valid & out_ready;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rs_d      = rs_q;
      rt_d      = rt_q;
      rpc_d     = rpc_q;
      rec_d     = rec_q;
      drop_d    = drop_q;
      fifo_push = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (retire_valid) begin
               rpc_d   = retire_pc;
               rs_d    = retire_instr[RS_MSB:RS_LSB];
               rt_d    = retire_instr[RT_MSB:RT_LSB];
               cnt_d   = CW'(READ_LAT);
               state_d = ST_READ;
            end
         end
         ST_READ: begin
            if (cnt_q == CW'(1)) begin
               rec_d.retire_pc = rpc_q;
               rec_d.pc        = pc;
               rec_d.rs_value  = rs_value;
               rec_d.rt_value  = rt_value;
               rec_d.rd_value  = rd_value;
`ifdef TRACE_CAPTURE_STAMP_EN
               rec_d.stamp     = stamp_q;
`endif
               state_d = ST_PUSH;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_PUSH: begin
            state_d = ST_IDLE;
            if (!fifo_full || fifo_pop) begin
               fifo_push = 1'b1;
            end else if (drop_q != 16'hFFFF) begin
               drop_d = drop_q + 16'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         rs_q    <= '0;
         rt_q    <= '0;
         rpc_q   <= '0;
         rec_q   <= '0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rs_q    <= rs_d;
         rt_q    <= rt_d;
         rpc_q   <= rpc_d;
         rec_q   <= rec_d;
         drop_q  <= drop_d;
      end
   end

   trace_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (REC_W)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push_i  (fifo_push),
      .pop_i   (out_ready),
      .data_i  (rec_q),
      .data_o  (out_data),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign retire_ready = (state_q == ST_IDLE);
   assign out_valid    = ~fifo_empty;
   assign rs           = rs_q;
   assign rt           = rt_q;
   assign drop_cnt     = drop_q;

endmodule

// File: tb/tb_trace_capture.sv
// Directed bench for trace_capture: instance A (DEPTH 4, READ_LAT 1) with a record scoreboard,
// instance B (DEPTH 4, READ_LAT 3) for the reset-during-READ sequence.
module tb_trace_capture;
   import trace_pkg::*;

   localparam int DEPTH = 4;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset_n, reset_b_n;
   logic              retire_valid, retire_valid_b;
   logic              retire_ready, retire_ready_b;
   logic [31:0]       retire_instr, retire_pc, rs_value, rt_value, rd_value, pc;
   logic [4:0]        rs, rt, rs_b, rt_b;
   logic              out_valid, out_valid_b, out_ready, out_ready_b;
   logic [REC_W-1:0]  out_data, out_data_b;
   logic [CNT_W-1:0]  fifo_count, fifo_count_b;
   logic [15:0]       drop_cnt, drop_cnt_b;

   int total = 0;
   int bad   = 0;
   logic [REC_W-1:0] exp_q[$];
`ifdef TRACE_CAPTURE_STAMP_EN
   trace_rec_t r1, r2;
`endif

   trace_capture #(.DEPTH(DEPTH), .READ_LAT(1)) u_dut_a (
      .clk (clk), .reset_n (reset_n),
      .retire_valid (retire_valid), .retire_ready (retire_ready),
      .retire_instr (retire_instr), .retire_pc (retire_pc),
      .rs (rs), .rt (rt),
      .rs_value (rs_value), .rt_value (rt_value), .rd_value (rd_value), .pc (pc),
      .out_valid (out_valid), .out_ready (out_ready), .out_data (out_data),
      .fifo_count (fifo_count), .drop_cnt (drop_cnt)
   );

   trace_capture #(.DEPTH(DEPTH), .READ_LAT(3)) u_dut_b (
      .clk (clk), .reset_n (reset_b_n),
      .retire_valid (retire_valid_b), .retire_ready (retire_ready_b),
      .retire_instr (retire_instr), .retire_pc (retire_pc),
      .rs (rs_b), .rt (rt_b),
      .rs_value (rs_value), .rt_value (rt_value), .rd_value (rd_value), .pc (pc),
      .out_valid (out_valid_b), .out_ready (out_ready_b), .out_data (out_data_b),
      .fifo_count (fifo_count_b), .drop_cnt (drop_cnt_b)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [REC_W-1:0] mk_rec(input logic [31:0] rpc, input logic [31:0] p,
                                               input logic [31:0] a, input logic [31:0] b,
                                               input logic [31:0] d);
      trace_rec_t r;
      r = '0;
      r.retire_pc = rpc;
      r.pc        = p;
      r.rs_value  = a;
      r.rt_value  = b;
      r.rd_value  = d;
      return r;
   endfunction

   function automatic logic [REC_W-1:0] no_stamp(input logic [REC_W-1:0] v);
      trace_rec_t r;
      r = v;
`ifdef TRACE_CAPTURE_STAMP_EN
      r.stamp = '0;
`endif
      return r;
   endfunction

   task automatic set_data(input logic [31:0] instr, input logic [31:0] rpc, input logic [31:0] p,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] d);
      retire_instr = instr;
      retire_pc    = rpc;
      pc           = p;
      rs_value     = a;
      rt_value     = b;
      rd_value     = d;
   endtask

   // Returns in cycle T+1 of the accepted retire; data inputs stay put until the next call.
   task automatic retire_a(input int i, input bit stored);
      int n = 0;
      while (retire_ready !== 1'b1 && n < 20) begin step(); n++; end
      check("a_ready_wait", retire_ready, 1'b1);
      set_data({6'h0, 5'(i), 5'(i + 3), 16'h0}, 32'h2000 + 32'(i * 4), 32'h3000 + 32'(i),
               32'hA000 + 32'(i), 32'hB000 + 32'(i), 32'hC000 + 32'(i));
      retire_valid = 1'b1;
      if (stored) exp_q.push_back(mk_rec(retire_pc, pc, rs_value, rt_value, rd_value));
      step();
      retire_valid = 1'b0;
   endtask

   task automatic retire_b(input int i);
      int n = 0;
      while (retire_ready_b !== 1'b1 && n < 20) begin step(); n++; end
      check("b_ready_wait", retire_ready_b, 1'b1);
      set_data({6'h0, 5'(i), 5'(i + 1), 16'h0}, 32'h5000 + 32'(i), 32'h6000, 32'h1, 32'h2, 32'h3);
      retire_valid_b = 1'b1;
      step();
      retire_valid_b = 1'b0;
   endtask

   task automatic drain_a(input int cnt);
      for (int i = 0; i < cnt; i++) begin
         int n = 0;
         while (out_valid !== 1'b1 && n < 20) begin step(); n++; end
         check("drain_valid", out_valid, 1'b1);
         check("sb_nonempty", exp_q.size() != 0, 1'b1);
         if (exp_q.size() != 0) check("drain_data", no_stamp(out_data), no_stamp(exp_q.pop_front()));
         out_ready = 1'b1;
         step();
         out_ready = 1'b0;
      end
   endtask

   initial begin
      int acc;
      reset_n = 1'b0; reset_b_n = 1'b0;
      retire_valid = 1'b0; retire_valid_b = 1'b0;
      out_ready = 1'b0; out_ready_b = 1'b0;
      set_data('0, '0, '0, '0, '0, '0);
      step(); step();

      check("rst_rs", rs, 5'd0);
      check("rst_rt", rt, 5'd0);
      check("rst_ready", retire_ready, 1'b1);
      check("rst_valid", out_valid, 1'b0);
      check("rst_data", out_data, '0);
      check("rst_count", fifo_count, '0);
      check("rst_drop", drop_cnt, 16'd0);
      reset_n = 1'b1; reset_b_n = 1'b1;
      step();

      // single retire, READ_LAT=1
      set_data(32'h012A4020, 32'h0000_0040, 32'h0000_0044, 32'd5, 32'd7, 32'd12);
      check("single_ready_T", retire_ready, 1'b1);
      retire_valid = 1'b1;
      exp_q.push_back(mk_rec(32'h40, 32'h44, 32'd5, 32'd7, 32'd12));
      step();
      retire_valid = 1'b0;
      check("single_rs_T1", rs, 5'd9);
      check("single_rt_T1", rt, 5'd10);
      check("single_ready_T1", retire_ready, 1'b0);
      check("single_valid_T1", out_valid, 1'b0);
      step();
      check("single_ready_T2", retire_ready, 1'b0);
      check("single_valid_T2", out_valid, 1'b0);
      step();
      check("single_valid_T3", out_valid, 1'b1);
      check("single_count_T3", fifo_count, 3'd1);
      drain_a(1);
      check("single_count_after", fifo_count, 3'd0);

      // back-pressure: retire_valid held high for 10 cycles
      acc = 0;
      for (int k = 0; k < 10; k++) begin
         if (k % 3 == 0) begin
            set_data({6'h0, 5'(k + 1), 5'(k + 2), 16'h1234}, 32'h100 + 32'(k * 4), 32'h900 + 32'(k),
                     32'h1000 + 32'(k), 32'h2000 + 32'(k), 32'h3000 + 32'(k));
            exp_q.push_back(mk_rec(retire_pc, pc, rs_value, rt_value, rd_value));
         end
         retire_valid = 1'b1;
         check("bp_ready", retire_ready, (k % 3 == 0));
         if (k % 3 == 1) check("bp_rs", rs, 5'(k));
         if (retire_ready === 1'b1) acc++;
         step();
      end
      retire_valid = 1'b0;
      check("bp_accepted", acc, 4);
      step(); step();
      check("bp_count", fifo_count, 3'd4);
      check("bp_drop", drop_cnt, 16'd0);
      drain_a(4);

      // full / drop: 6 retires into an undrained DEPTH=4 FIFO
      for (int i = 0; i < 6; i++) retire_a(i, i < 4);
      step(); step();
      check("full_count", fifo_count, 3'd4);
      check("full_drop", drop_cnt, 16'd2);
      check("full_valid", out_valid, 1'b1);

      // full with a pop coinciding with PUSH
      retire_a(7, 1'b1);
      step();
      out_ready = 1'b1;
      check("fpop_valid", out_valid, 1'b1);
      check("fpop_head", no_stamp(out_data), no_stamp(exp_q.pop_front()));
      step();
      out_ready = 1'b0;
      check("fpop_count", fifo_count, 3'd4);
      check("fpop_drop", drop_cnt, 16'd2);
      drain_a(4);
      check("fpop_empty", fifo_count, 3'd0);
      check("sb_empty", exp_q.size(), 0);

      // reset during READ on instance B (READ_LAT=3) after filling and dropping
      for (int i = 0; i < 5; i++) retire_b(i);
      step(); step(); step(); step();
      check("b_fill_count", fifo_count_b, 3'd4);
      check("b_fill_drop", drop_cnt_b, 16'd1);
      retire_b(9);
      step();
      reset_b_n = 1'b0;
      #1;
      check("b_rst_rs", rs_b, 5'd0);
      check("b_rst_rt", rt_b, 5'd0);
      check("b_rst_ready", retire_ready_b, 1'b1);
      check("b_rst_valid", out_valid_b, 1'b0);
      check("b_rst_data", out_data_b, '0);
      check("b_rst_count", fifo_count_b, '0);
      check("b_rst_drop", drop_cnt_b, 16'd0);
      step();
      reset_b_n = 1'b1;
      step();
      set_data(32'h012A4020, 32'h0000_0040, 32'h0000_0044, 32'd5, 32'd7, 32'd12);
      check("b_single_ready", retire_ready_b, 1'b1);
      retire_valid_b = 1'b1;
      step();
      retire_valid_b = 1'b0;
      check("b_single_rs", rs_b, 5'd9);
      check("b_single_rt", rt_b, 5'd10);
      step(); step(); step();
      check("b_single_valid_T4", out_valid_b, 1'b0);
      step();
      check("b_single_valid_T5", out_valid_b, 1'b1);
      check("b_single_data", no_stamp(out_data_b), mk_rec(32'h40, 32'h44, 32'd5, 32'd7, 32'd12));
      check("b_single_count", fifo_count_b, 3'd1);

`ifdef TRACE_CAPTURE_STAMP_EN
      // two retires five cycles apart
      retire_a(20, 1'b1);
      step(); step(); step(); step();
      retire_a(21, 1'b1);
      step(); step();
      check("stamp_count", fifo_count, 3'd2);
      r1 = out_data;
      check("stamp_rec1", no_stamp(out_data), no_stamp(exp_q.pop_front()));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      r2 = out_data;
      check("stamp_rec2", no_stamp(out_data), no_stamp(exp_q.pop_front()));
      check("stamp_delta", r2.stamp - r1.stamp, 32'd5);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
